mips_reg_write_arbiter: RTL and testbench
=========================================

// Module: mips_reg_write_arbiter
// PURPOSE
//  Owns the single write port of the 8x32 MIPS register file. After reset it sequences an
//  init sweep (the register file has no reset) writing 0 to registers 1..7, then shares the
//  write port between two writeback requesters (A: ALU result, B: memory load) with
//  round-robin arbitration and a valid/ready handshake. Outputs drive the register file directly.
// PARAMETERS
//  DATA_W  32  width of write data
//  ADDR_W  3   register index width; NUM_REGS = 2**ADDR_W (8)
// PORTS
//  clk               in   1       clock, all logic on posedge
//  reset             in   1       synchronous, active-high
//  a_valid           in   1       requester A has a write pending
//  a_reg             in   ADDR_W  requester A destination register
//  a_data            in   DATA_W  requester A write data
//  a_ready           out  1       A's write accepted this cycle (combinational)
//  b_valid/b_reg/b_data/b_ready   same as A, for requester B
//  signal_reg_write  out  1       register file write enable (registered)
//  write_reg         out  ADDR_W  register file write index (registered)
//  write_data        out  DATA_W  register file write data (registered)
//  init_done         out  1       high once init sweep complete (registered)
//  conflict_count    out  16      only with MIPS_REG_ARB_STATS_EN
// BEHAVIOUR
//  - Reset (sync, active-high) values: state=INIT, sweep ptr=1, rr priority=A,
//    signal_reg_write=0, write_reg=0, write_data=0, init_done=0, conflict_count=0.
//  - a_ready=b_ready=0 whenever reset=1 or state=INIT.
//  - INIT: each cycle registers signal_reg_write=1, write_reg=ptr, write_data=0; ptr++.
//    Cycle after reset deasserts: write reg 1; 7th cycle: reg 7; then state=RUN and
//    init_done=1 from the 8th cycle. ptr wraps never (stops at NUM_REGS-1).
//  - RUN: transfer = valid & ready. At most one ready per cycle.
//    Only A valid -> a_ready=1; only B valid -> b_ready=1; both -> grant side holding priority.
//    After any transfer priority moves to the other side; no transfer -> priority unchanged.
//  - Latency 1 cycle: transfer in cycle N -> cycle N+1 signal_reg_write=1, write_reg/write_data
//    = granted reg/data. Throughput 1 write/cycle.
//  - No transfer in cycle N -> cycle N+1 signal_reg_write=0; write_reg/write_data hold.
//  - Destination reg 0: request accepted (ready=1, counts for round robin) but
//    signal_reg_write=0 next cycle; write_reg/write_data hold.
//  - Both requesters targeting the same nonzero reg: served in arbitration order; later
//    write lands last. No merging.
//  - Requester rule: hold valid/reg/data stable until ready; arbiter samples only on transfer.
//  - Reset mid-RUN or mid-INIT: any request in the reset cycle is not accepted; outputs return
//    to reset values next edge; sweep restarts at reg 1.
//  - States: INIT -> RUN (after reg NUM_REGS-1 written); RUN -> INIT only via reset.
// CONFIGURATION
//  MIPS_REG_ARB_STATS_EN defined: port conflict_count present; increments by 1 on every RUN
//   cycle with a_valid=b_valid=1 (reset not asserted); saturates at 16'hFFFF; never counts in INIT.
//  Not defined: port and counter absent; all other behaviour identical.
// TESTING
//  1. reset=1 one cycle, no requests -> writes reg1..reg7 =0 on cycles 1..7, init_done=1 cycle 8,
//     a_ready/b_ready=0 throughout cycles 0..7.
//  2. After init, a_valid=1 a_reg=3 a_data=32'hDEADBEEF -> a_ready=1 same cycle; next cycle
//     signal_reg_write=1 write_reg=3 write_data=32'hDEADBEEF; following cycle signal_reg_write=0.
//  3. a_valid,b_valid held 4 cycles (A reg2/32'h1, B reg5/32'h2), priority=A -> grants A,B,A,B;
//     write_reg sequence 2,5,2,5 on cycles +1..+4.
//  4. b_valid=1 b_reg=0 b_data=32'h1234 -> b_ready=1; next cycle signal_reg_write=0, write_reg
//     and write_data unchanged; then a+b valid -> A granted (priority moved to A).
//  5. reset asserted during RUN with both valid -> both ready=0 that cycle, next cycle
//     signal_reg_write=0, init_done=0; sweep reg1..7 repeats, ready low until init_done.
//  6. STATS_EN: 3 cycles both valid then 2 cycles A only -> conflict_count=3; force 65535
//     conflict cycles+1 -> count holds 16'hFFFF; build without macro compiles, port absent.

Source files
------------

// File: rtl/mips_reg_write_arbiter_if.sv
// rtl/mips_reg_write_arbiter_if.sv - writeback request and register file write bus for the arbiter
interface mips_reg_write_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3
);
  logic              a_valid;
  logic [ADDR_W-1:0] a_reg;
  logic [DATA_W-1:0] a_data;
  logic              a_ready;
  logic              b_valid;
  logic [ADDR_W-1:0] b_reg;
  logic [DATA_W-1:0] b_data;
  logic              b_ready;
  logic              signal_reg_write;
  logic [ADDR_W-1:0] write_reg;
  logic [DATA_W-1:0] write_data;
  logic              init_done;

  modport master (
    output a_valid, a_reg, a_data, b_valid, b_reg, b_data,
    input  a_ready, b_ready, signal_reg_write, write_reg, write_data, init_done
  );

  modport slave (
    input  a_valid, a_reg, a_data, b_valid, b_reg, b_data,
    output a_ready, b_ready, signal_reg_write, write_reg, write_data, init_done
  );
endinterface

// File: rtl/mips_reg_write_arbiter.sv
// rtl/mips_reg_write_arbiter.sv - register file write port owner: init sweep then round-robin writeback (optional MIPS_REG_ARB_STATS_EN)
module mips_reg_write_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  mips_reg_write_arbiter_if.slave bus
`ifdef MIPS_REG_ARB_STATS_EN
  ,
  output logic [15:0]             conflict_count_o
`endif
);

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  localparam logic [ADDR_W-1:0] LAST_REG = '1;

  state_e            state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic              prio_q;   // 0: A holds priority, 1: B holds priority
  logic              swr_q;
  logic [ADDR_W-1:0] wreg_q;
  logic [DATA_W-1:0] wdata_q;
  logic              init_done_q;

  logic run_d;
  logic grant_a_d;
  logic grant_b_d;

  // Grant decision: only in RUN outside reset, one side at most, priority breaks ties
  always_comb begin
    run_d     = (state_q == ST_RUN) && !reset_i;
    grant_a_d = run_d && bus.a_valid && (!bus.b_valid || !prio_q);
    grant_b_d = run_d && bus.b_valid && (!bus.a_valid ||  prio_q);
  end

  assign bus.a_ready          = grant_a_d;
  assign bus.b_ready          = grant_b_d;
  assign bus.signal_reg_write = swr_q;
  assign bus.write_reg        = wreg_q;
  assign bus.write_data       = wdata_q;
  assign bus.init_done        = init_done_q;

  // Sweep/run state machine with registered register-file outputs
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= ST_INIT;
      ptr_q       <= ADDR_W'(1);
      prio_q      <= 1'b0;
      swr_q       <= 1'b0;
      wreg_q      <= '0;
      wdata_q     <= '0;
      init_done_q <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          // The last sweep write is visible for one cycle before RUN opens the port
          if (swr_q && (wreg_q == LAST_REG)) begin
            state_q     <= ST_RUN;
            init_done_q <= 1'b1;
            swr_q       <= 1'b0;
          end else begin
            swr_q   <= 1'b1;
            wreg_q  <= ptr_q;
            wdata_q <= '0;
            if (ptr_q != LAST_REG) begin
              ptr_q <= ptr_q + ADDR_W'(1);
            end
          end
        end
        ST_RUN: begin
          if (grant_a_d) begin
            prio_q <= 1'b1;
            swr_q  <= (bus.a_reg != '0);
            if (bus.a_reg != '0) begin
              wreg_q  <= bus.a_reg;
              wdata_q <= bus.a_data;
            end
          end else if (grant_b_d) begin
            prio_q <= 1'b0;
            swr_q  <= (bus.b_reg != '0);
            if (bus.b_reg != '0) begin
              wreg_q  <= bus.b_reg;
              wdata_q <= bus.b_data;
            end
          end else begin
            swr_q <= 1'b0;
          end
        end
        default: state_q <= ST_INIT;
      endcase
    end
  end

`ifdef MIPS_REG_ARB_STATS_EN
  logic [15:0] conflict_q;

  // Count RUN cycles where both requesters compete, saturating
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      conflict_q <= '0;
    end else if ((state_q == ST_RUN) && bus.a_valid && bus.b_valid && (conflict_q != 16'hFFFF)) begin
      conflict_q <= conflict_q + 16'd1;
    end
  end

  assign conflict_count_o = conflict_q;
`endif

endmodule

// File: tb/tb_mips_reg_write_arbiter.sv
// tb/tb_mips_reg_write_arbiter.sv - directed self-checking bench for mips_reg_write_arbiter
module tb_mips_reg_write_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  mips_reg_write_arbiter_if #(.DATA_W(32), .ADDR_W(3)) bus ();

`ifdef MIPS_REG_ARB_STATS_EN
  logic [15:0] conflict_count;
`endif

  mips_reg_write_arbiter #(.DATA_W(32), .ADDR_W(3)) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus.slave)
`ifdef MIPS_REG_ARB_STATS_EN
    ,
    .conflict_count_o (conflict_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input logic v, input logic [2:0] r, input logic [31:0] d);
    bus.a_valid = v; bus.a_reg = r; bus.a_data = d;
  endtask

  task automatic set_b(input logic v, input logic [2:0] r, input logic [31:0] d);
    bus.b_valid = v; bus.b_reg = r; bus.b_data = d;
  endtask

  task automatic check_ready(input string tag, input logic ea, input logic eb);
    #1;
    check({tag, " a_ready"}, 32'(bus.a_ready), 32'(ea));
    check({tag, " b_ready"}, 32'(bus.b_ready), 32'(eb));
  endtask

  task automatic check_wr(input string tag, input logic swr, input logic [2:0] r, input logic [31:0] d);
    check({tag, " swr"},   32'(bus.signal_reg_write), 32'(swr));
    check({tag, " wreg"},  32'(bus.write_reg), 32'(r));
    check({tag, " wdata"}, bus.write_data, d);
  endtask

  // Sweep after reset release: reg k written in cycle k, init_done in cycle 8
  task automatic check_sweep(input string tag, input logic req_a_exp);
    for (int k = 1; k <= 7; k++) begin
      tick();
      check_wr($sformatf("%s sweep%0d", tag, k), 1'b1, 3'(k), 32'h0);
      check($sformatf("%s sweep%0d init_done", tag, k), 32'(bus.init_done), 32'h0);
      check_ready($sformatf("%s sweep%0d", tag, k), 1'b0, 1'b0);
    end
    tick();
    check({tag, " init_done"}, 32'(bus.init_done), 32'h1);
    check({tag, " post-sweep swr"}, 32'(bus.signal_reg_write), 32'h0);
    check_ready({tag, " run open"}, req_a_exp, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    set_a(1'b0, 3'd0, 32'h0);
    set_b(1'b0, 3'd0, 32'h0);
    check_ready("reset cycle", 1'b0, 1'b0);
    tick();
    reset = 1'b0;
    check_wr("reset values", 1'b0, 3'd0, 32'h0);
    check("reset init_done", 32'(bus.init_done), 32'h0);
`ifdef MIPS_REG_ARB_STATS_EN
    check("reset conflict", 32'(conflict_count), 32'h0);
`endif
    check_sweep("t1", 1'b0);

    // Single A write to reg 3; priority then moves to B
    set_a(1'b1, 3'd3, 32'hDEADBEEF);
    check_ready("t2 grant", 1'b1, 1'b0);
    tick();
    set_a(1'b0, 3'd0, 32'h0);
    check_wr("t2 write", 1'b1, 3'd3, 32'hDEADBEEF);
    tick();
    check_wr("t2 idle", 1'b0, 3'd3, 32'hDEADBEEF);

    // B writes reg 0: accepted, suppressed, outputs hold; priority back to A
    set_b(1'b1, 3'd0, 32'h1234);
    check_ready("t4 grant", 1'b0, 1'b1);
    tick();
    set_b(1'b0, 3'd0, 32'h0);
    check_wr("t4 reg0 suppressed", 1'b0, 3'd3, 32'hDEADBEEF);

    // Both valid for 4 cycles: grants A,B,A,B
    set_a(1'b1, 3'd2, 32'h1);
    set_b(1'b1, 3'd5, 32'h2);
    check_ready("t3 c0", 1'b1, 1'b0);
    tick();
    check_wr("t3 w0", 1'b1, 3'd2, 32'h1);
    check_ready("t3 c1", 1'b0, 1'b1);
    tick();
    check_wr("t3 w1", 1'b1, 3'd5, 32'h2);
    check_ready("t3 c2", 1'b1, 1'b0);
    tick();
    check_wr("t3 w2", 1'b1, 3'd2, 32'h1);
    check_ready("t3 c3", 1'b0, 1'b1);
    tick();
    set_a(1'b0, 3'd0, 32'h0);
    set_b(1'b0, 3'd0, 32'h0);
    check_wr("t3 w3", 1'b1, 3'd5, 32'h2);
    tick();
    check_wr("t3 idle", 1'b0, 3'd5, 32'h2);
`ifdef MIPS_REG_ARB_STATS_EN
    check("t3 conflict", 32'(conflict_count), 32'd4);

    // Three conflict cycles then two A-only cycles
    set_a(1'b1, 3'd1, 32'h11);
    set_b(1'b1, 3'd6, 32'h22);
    for (int i = 0; i < 3; i++) tick();
    set_b(1'b0, 3'd0, 32'h0);
    for (int i = 0; i < 2; i++) tick();
    set_a(1'b0, 3'd0, 32'h0);
    check("t6 conflict", 32'(conflict_count), 32'd7);

    // Saturation
    set_a(1'b1, 3'd1, 32'h11);
    set_b(1'b1, 3'd6, 32'h22);
    for (int i = 0; i < 65536; i++) tick();
    check("t6 saturate", 32'(conflict_count), 32'hFFFF);
    tick();
    check("t6 saturate hold", 32'(conflict_count), 32'hFFFF);
`endif

    // Reset in RUN with both requesters pending; keep them pending through the sweep
    set_a(1'b1, 3'd4, 32'hA5A5A5A5);
    set_b(1'b1, 3'd7, 32'h5A5A5A5A);
    reset = 1'b1;
    check_ready("t5 reset cycle", 1'b0, 1'b0);
    tick();
    reset = 1'b0;
    check_wr("t5 after reset", 1'b0, 3'd0, 32'h0);
    check("t5 init_done", 32'(bus.init_done), 32'h0);
    check_ready("t5 c0", 1'b0, 1'b0);
    check_sweep("t5", 1'b1);
`ifdef MIPS_REG_ARB_STATS_EN
    check("t5 conflict after sweep", 32'(conflict_count), 32'h0);
`endif
    tick();
    set_a(1'b0, 3'd0, 32'h0);
    set_b(1'b0, 3'd0, 32'h0);
    check_wr("t5 first write", 1'b1, 3'd4, 32'hA5A5A5A5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
